// File: rtl/timer_share_arbiter_if.sv
// Bundle between the timer share arbiter, its requesting sequencers and the
// shared TimeParameters/Timer1Hz pair.
interface timer_share_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] reqInterval;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 startTimer;
  logic [1:0]           interval;
  logic                 expired;
  logic                 busy;

  modport slave (
    input  req, reqInterval, expired,
    output grant, done, startTimer, interval, busy
  );

  modport master (
    output req, reqInterval, expired,
    input  grant, done, startTimer, interval, busy
  );
endinterface

// File: rtl/timer_share_arbiter.sv
// Round-robin owner of the single shared 1 Hz timer: loads the winner's
// interval, fires one start pulse and returns the expiry as a one-cycle done.
module timer_share_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  timer_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   winner_r;
  logic [IDX_W:0]     pick_s;
  logic               pick_valid_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [1:0]         pick_interval_s;

  // First asserted request at or after ptr; the wrap uses a compare-and-subtract
  // so non-power-of-two requester counts are handled.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    int               sum;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
      idx = IDX_W'(sum);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] w);
    return (int'(w) >= NUM_REQ - 1) ? '0 : IDX_W'(int'(w) + 1);
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] w);
    logic [NUM_REQ-1:0] oh;
    for (int i = 0; i < NUM_REQ; i++) begin
      oh[i] = (i == int'(w)) ? 1'b1 : 1'b0;
    end
    return oh;
  endfunction

  function automatic logic [1:0] interval_of(input logic [2*NUM_REQ-1:0] ri,
                                             input logic [IDX_W-1:0]     w);
    logic [1:0] iv;
    iv = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == int'(w)) begin
        iv = ri[2*i +: 2];
      end
    end
    return iv;
  endfunction

  // Round-robin candidate for the next grant.
  always_comb begin
    pick_s          = rr_pick(bus.req, rr_ptr_r);
    pick_valid_s    = pick_s[IDX_W];
    pick_idx_s      = pick_s[IDX_W-1:0];
    pick_interval_s = interval_of(bus.reqInterval, pick_idx_s);
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      rr_ptr_r       <= '0;
      winner_r       <= '0;
      bus.grant      <= '0;
      bus.done       <= '0;
      bus.startTimer <= 1'b0;
      bus.interval   <= 2'b00;
      bus.busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus.done       <= '0;
          bus.startTimer <= 1'b0;
          if (pick_valid_s) begin
            winner_r     <= pick_idx_s;
            bus.interval <= pick_interval_s;
            bus.grant    <= one_hot(pick_idx_s);
            bus.busy     <= 1'b1;
            state_r      <= LOAD;
          end else begin
            bus.grant    <= '0;
            bus.busy     <= 1'b0;
            state_r      <= IDLE;
          end
        end
        LOAD: begin
          // Any expiry seen here belongs to the previous owner's timer run.
          bus.startTimer <= 1'b1;
          state_r        <= RUN;
        end
        RUN: begin
          bus.startTimer <= 1'b0;
          if (bus.expired) begin
            bus.done <= one_hot(winner_r);
            state_r  <= DONE;
          end else if (!bus.req[winner_r]) begin
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            rr_ptr_r  <= next_idx(winner_r);
            state_r   <= IDLE;
          end else begin
            state_r   <= RUN;
          end
        end
        DONE: begin
          bus.done  <= '0;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          rr_ptr_r  <= next_idx(winner_r);
          state_r   <= IDLE;
        end
        default: begin
          state_r        <= IDLE;
          bus.grant      <= '0;
          bus.done       <= '0;
          bus.startTimer <= 1'b0;
          bus.busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Directed bench for timer_share_arbiter with hand-computed expectations.
module tb_timer_share_arbiter;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] exp_g;

  always #5 clock = ~clock;

  timer_share_arbiter_if #(.NUM_REQ(3)) bus ();

  timer_share_arbiter #(.NUM_REQ(3), .IDX_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      check_eq("grant_onehot0", 8'($onehot0(bus.grant)), 8'h01);
      check_eq("done_in_grant", 8'(bus.done & ~bus.grant), 8'h00);
      check_eq("start_in_busy", 8'(bus.startTimer & ~bus.busy), 8'h00);
    end
  end

  initial begin
    reset = 1'b0;
    bus.req = 3'b000;
    bus.reqInterval = 6'b000000;
    bus.expired = 1'b0;
    #13;
    check_eq("rst_grant", 8'(bus.grant), 8'h00);
    check_eq("rst_done", 8'(bus.done), 8'h00);
    check_eq("rst_start", 8'(bus.startTimer), 8'h00);
    check_eq("rst_interval", 8'(bus.interval), 8'h00);
    check_eq("rst_busy", 8'(bus.busy), 8'h00);
    tick();
    reset = 1'b1;

    // Single request from requester 1 through a full interval.
    bus.req = 3'b010;
    bus.reqInterval = 6'b001100;
    tick();
    check_eq("t2_grant", 8'(bus.grant), 8'h02);
    check_eq("t2_interval", 8'(bus.interval), 8'h03);
    check_eq("t2_busy", 8'(bus.busy), 8'h01);
    check_eq("t2_start_early", 8'(bus.startTimer), 8'h00);
    tick();
    check_eq("t2_start", 8'(bus.startTimer), 8'h01);
    check_eq("t2_grant_load", 8'(bus.grant), 8'h02);
    tick();
    check_eq("t2_start_off", 8'(bus.startTimer), 8'h00);
    bus.expired = 1'b1;
    tick();
    bus.expired = 1'b0;
    check_eq("t2_done", 8'(bus.done), 8'h02);
    check_eq("t2_grant_done", 8'(bus.grant), 8'h02);
    bus.req = 3'b000;
    tick();
    check_eq("t2_done_off", 8'(bus.done), 8'h00);
    check_eq("t2_grant_off", 8'(bus.grant), 8'h00);
    check_eq("t2_busy_off", 8'(bus.busy), 8'h00);

    // Expiry in IDLE and LOAD is ignored; expiry beats cancel in RUN.
    bus.expired = 1'b1;
    tick();
    bus.expired = 1'b0;
    check_eq("t5_idle_busy", 8'(bus.busy), 8'h00);
    check_eq("t5_idle_done", 8'(bus.done), 8'h00);
    bus.req = 3'b010;
    tick();
    check_eq("t5_grant", 8'(bus.grant), 8'h02);
    bus.expired = 1'b1;
    tick();
    bus.expired = 1'b0;
    check_eq("t5_load_start", 8'(bus.startTimer), 8'h01);
    check_eq("t5_load_done", 8'(bus.done), 8'h00);
    bus.expired = 1'b1;
    bus.req = 3'b000;
    tick();
    bus.expired = 1'b0;
    check_eq("t5_exp_wins", 8'(bus.done), 8'h02);
    tick();
    check_eq("t5_grant_off", 8'(bus.grant), 8'h00);

    // Interval latched at grant time.
    bus.reqInterval = 6'b000001;
    bus.req = 3'b001;
    tick();
    check_eq("t6_grant", 8'(bus.grant), 8'h01);
    check_eq("t6_interval", 8'(bus.interval), 8'h01);
    bus.reqInterval = 6'b000010;
    tick();
    tick();
    check_eq("t6_interval_held", 8'(bus.interval), 8'h01);
    bus.expired = 1'b1;
    tick();
    bus.expired = 1'b0;
    check_eq("t6_done", 8'(bus.done), 8'h01);
    check_eq("t6_interval_done", 8'(bus.interval), 8'h01);
    bus.req = 3'b000;
    tick();
    bus.req = 3'b001;
    tick();
    check_eq("t6_regrant", 8'(bus.grant), 8'h01);
    check_eq("t6_interval_new", 8'(bus.interval), 8'h02);
    tick();
    tick();

    // Asynchronous reset mid-RUN abandons the interval.
    bus.req = 3'b000;
    reset = 1'b0;
    #1;
    check_eq("mr_grant", 8'(bus.grant), 8'h00);
    check_eq("mr_done", 8'(bus.done), 8'h00);
    check_eq("mr_start", 8'(bus.startTimer), 8'h00);
    check_eq("mr_interval", 8'(bus.interval), 8'h00);
    check_eq("mr_busy", 8'(bus.busy), 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("mr_hold_done", 8'(bus.done), 8'h00);
    end
    reset = 1'b1;
    tick();
    check_eq("mr_after_done", 8'(bus.done), 8'h00);
    check_eq("mr_after_grant", 8'(bus.grant), 8'h00);

    // All requesters high: round-robin 001, 010, 100.
    bus.req = 3'b111;
    for (int n = 0; n < 3; n++) begin
      exp_g = 3'b001 << n;
      tick();
      check_eq("t3_grant", 8'(bus.grant), 8'(exp_g));
      tick();
      check_eq("t3_start", 8'(bus.startTimer), 8'h01);
      tick();
      bus.expired = 1'b1;
      tick();
      bus.expired = 1'b0;
      check_eq("t3_done", 8'(bus.done), 8'(exp_g));
      bus.req = bus.req & ~exp_g;
      tick();
      check_eq("t3_done_once", 8'(bus.done), 8'h00);
      check_eq("t3_grant_off", 8'(bus.grant), 8'h00);
    end

    // Cancel mid-RUN: no done, pending requester 2 served next.
    bus.req = 3'b001;
    tick();
    check_eq("t4_grant", 8'(bus.grant), 8'h01);
    tick();
    tick();
    bus.req = 3'b100;
    tick();
    check_eq("t4_cancel_grant", 8'(bus.grant), 8'h00);
    check_eq("t4_cancel_done", 8'(bus.done), 8'h00);
    check_eq("t4_cancel_busy", 8'(bus.busy), 8'h00);
    tick();
    check_eq("t4_pending_grant", 8'(bus.grant), 8'h04);
    tick();
    tick();
    bus.expired = 1'b1;
    tick();
    bus.expired = 1'b0;
    check_eq("t4_done", 8'(bus.done), 8'h04);
    bus.req = 3'b000;
    tick();
    check_eq("t4_grant_off", 8'(bus.grant), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
